// File: rtl/spoc_perm_sched_pkg.sv
// ============================================================================
// spoc_perm_sched_pkg
// This package holds the shared constants, index widths and FSM encoding for
// the SpoC-64 permutation scheduler.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package spoc_perm_sched_pkg;

    localparam int SPOC_NUM_STEPS       = 18;
    localparam int SPOC_ROUNDS_PER_STEP = 6;
    localparam int STEP_IDX_W           = 5;
    localparam int RND_IDX_W            = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_MIX   = 2'd2,
        ST_DONE  = 2'd3
    } perm_state_e;

endpackage

`default_nettype wire

// File: rtl/spoc_perm_sched_ctr.sv
// ============================================================================
// spoc_step_round_ctr
// This module contains the scheduler FSM and the nested round/step counter.
// The round counter advances by UNROLL and the step counter advances by one.
// Terminal-count flags drive the state transitions.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module spoc_step_round_ctr
    import spoc_perm_sched_pkg::*;
#(
    parameter int NUM_STEPS       = SPOC_NUM_STEPS,
    parameter int ROUNDS_PER_STEP = SPOC_ROUNDS_PER_STEP,
    parameter int UNROLL          = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  en_round,
    output logic                  en_step_mix,
    output logic [RND_IDX_W-1:0]  round_idx,
    output logic [STEP_IDX_W-1:0] step_idx,
    output logic                  perm_done
);

    localparam logic [RND_IDX_W-1:0]  RND_INC   = RND_IDX_W'(UNROLL);
    localparam logic [RND_IDX_W-1:0]  RND_LAST  = RND_IDX_W'(ROUNDS_PER_STEP - UNROLL);
    localparam logic [STEP_IDX_W-1:0] STEP_LAST = STEP_IDX_W'(NUM_STEPS - 1);

    perm_state_e           state_q, state_d;
    logic [RND_IDX_W-1:0]  round_q, round_d;
    logic [STEP_IDX_W-1:0] step_q,  step_d;
    logic                  round_last_w;
    logic                  step_last_w;

    assign round_last_w = (round_q == RND_LAST);
    assign step_last_w  = (step_q  == STEP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            step_q  <= step_d;
        end
    end

    // Outputs decode only registered state, so start never reaches them combinationally.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        step_d      = step_q;
        busy        = 1'b0;
        en_round    = 1'b0;
        en_step_mix = 1'b0;
        perm_done   = 1'b0;
        round_idx   = round_q;
        step_idx    = step_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ROUND;
                    round_d = '0;
                    step_d  = '0;
                end
            end
            ST_ROUND: begin
                busy     = 1'b1;
                en_round = 1'b1;
                if (round_last_w) begin
                    round_d = '0;
                    state_d = ST_MIX;
                end else begin
                    round_d = round_q + RND_INC;
                end
            end
            ST_MIX: begin
                busy        = 1'b1;
                en_step_mix = 1'b1;
                if (step_last_w) begin
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + STEP_IDX_W'(1);
                    state_d = ST_ROUND;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                perm_done = 1'b1;
                step_d    = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                round_d   = '0;
                step_d    = '0;
                round_idx = '0;
                step_idx  = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/spoc_perm_sched.sv
// ============================================================================
// spoc_perm_sched
// This is the top-level sequencer for the SpoC-64 sLiSCP-light permutation.
// Defining SPOC_PERM_CNT_EN adds the perm_count completed-permutation counter.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module spoc_perm_sched
    import spoc_perm_sched_pkg::*;
#(
    parameter int NUM_STEPS       = SPOC_NUM_STEPS,
    parameter int ROUNDS_PER_STEP = SPOC_ROUNDS_PER_STEP,
    parameter int UNROLL          = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  en_round,
    output logic                  en_step_mix,
    output logic [RND_IDX_W-1:0]  round_idx,
    output logic [STEP_IDX_W-1:0] step_idx,
    output logic                  perm_done
`ifdef SPOC_PERM_CNT_EN
    ,
    output logic [15:0]           perm_count
`endif
);

    spoc_step_round_ctr #(
        .NUM_STEPS       (NUM_STEPS),
        .ROUNDS_PER_STEP (ROUNDS_PER_STEP),
        .UNROLL          (UNROLL)
    ) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .en_round    (en_round),
        .en_step_mix (en_step_mix),
        .round_idx   (round_idx),
        .step_idx    (step_idx),
        .perm_done   (perm_done)
    );

`ifdef SPOC_PERM_CNT_EN
    logic [15:0] perm_count_q;

    // An aborted run never reaches DONE, so a reset mid-run leaves no count behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perm_count_q <= '0;
        end else if (perm_done) begin
            perm_count_q <= perm_count_q + 16'd1;
        end
    end

    assign perm_count = perm_count_q;
`endif

endmodule

`default_nettype wire
